// File: rtl/accel_bus_pkg.sv
// Shared states, strobe encodings and default window map for the accelerator memory bus.
// Pure declarations; imported by the copy master and its timeout timer.
package accel_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_GAP,
      ST_WR_REQ,
      ST_WR_GAP,
      ST_FIN
   } state_t;

   localparam logic [3:0]  WSTRB_READ = 4'h0;
   localparam logic [3:0]  WSTRB_WORD = 4'hF;
   localparam int          WORD_BYTES = 4;

   localparam logic [31:0] ADDR_WRITE = 32'h0110_0000;
   localparam logic [31:0] ADDR_READ  = 32'h0130_0000;
   localparam logic [31:0] ADDR_END   = 32'h0150_0000;

endpackage

// File: rtl/bus_timeout_timer.sv
// Counts cycles a bus request waits for ready; expired marks the TIMEOUT-th waiting cycle.
// Registered count, combinational expired; clear has priority over enable.
module bus_timeout_timer
   import accel_bus_pkg::*;
#(
   parameter int TIMEOUT = 64
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/accel_copy_master.sv
// Copy engine: per word one read then one write on the mem_valid/mem_ready bus, each followed by a gap cycle.
// Commands accepted only when idle/finishing; a request waiting TIMEOUT cycles is abandoned with err.
module accel_copy_master
   import accel_bus_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 64
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_src,
   input  logic [31:0]      cmd_dst,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic [31:0]      mem_rdata
);

   state_t           state_q, state_d;
   logic [31:0]      src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0] rem_q, rem_d, words_done_q, words_done_d;
   logic             mem_valid_q, mem_valid_d;
   logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]       mem_wstrb_q, mem_wstrb_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             tmr_clear, tmr_enable, tmr_expired;

   // The timer only runs while a request is outstanding; ready in the same cycle suppresses expiry.
   assign tmr_clear  = !((state_q == ST_RD_REQ) || (state_q == ST_WR_REQ));
   assign tmr_enable = !tmr_clear && !mem_ready;

   bus_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      rem_d        = rem_q;
      words_done_d = words_done_q;
      mem_wdata_d  = mem_wdata_q;
      err_d        = err_q;
      case (state_q)
         ST_IDLE, ST_FIN: begin
            state_d = ST_IDLE;
            if (cmd_valid && cmd_ready_q) begin
               src_d        = cmd_src;
               dst_d        = cmd_dst;
               rem_d        = cmd_len;
               err_d        = 1'b0;
               words_done_d = '0;
               state_d      = (cmd_len == '0) ? ST_FIN : ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            if (mem_ready) begin
               mem_wdata_d = mem_rdata;
               state_d     = ST_RD_GAP;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_RD_GAP: state_d = ST_WR_REQ;
         ST_WR_REQ: begin
            if (mem_ready) begin
               words_done_d = words_done_q + 1'b1;
               src_d        = src_q + 32'(WORD_BYTES);
               dst_d        = dst_q + 32'(WORD_BYTES);
               rem_d        = rem_q - 1'b1;
               state_d      = ST_WR_GAP;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_WR_GAP: state_d = (rem_q != '0) ? ST_RD_REQ : ST_FIN;
         default:   state_d = ST_IDLE;
      endcase

      // Bus and status outputs are registered images of the next state.
      mem_valid_d = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
      mem_wstrb_d = (state_d == ST_WR_REQ) ? WSTRB_WORD : WSTRB_READ;
      mem_addr_d  = mem_addr_q;
      if (state_d == ST_RD_REQ) begin
         mem_addr_d = src_d;
      end else if (state_d == ST_WR_REQ) begin
         mem_addr_d = dst_d;
      end
      busy_d      = !((state_d == ST_IDLE) || (state_d == ST_FIN));
      cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_FIN);
      done_d      = (state_d == ST_FIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         rem_q        <= '0;
         words_done_q <= '0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= WSTRB_READ;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cmd_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         rem_q        <= rem_d;
         words_done_q <= words_done_d;
         mem_valid_q  <= mem_valid_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cmd_ready_q  <= cmd_ready_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign words_done = words_done_q;
   assign mem_valid  = mem_valid_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_accel_copy_master.sv
// Bench for accel_copy_master: RAM + 8-operand product accelerator behind a decoder, registered-ready responder.
module tb_accel_copy_master;
   import accel_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_src = '0;
   logic [31:0] cmd_dst = '0;
   logic [15:0] cmd_len = '0;
   logic        busy, done, err;
   logic [15:0] words_done;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = '0;

   accel_copy_master #(.LEN_W(16), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .busy(busy), .done(done), .err(err), .words_done(words_done),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [0:1023];
   logic [31:0] acc_op [0:7];
   logic [31:0] log_addr [$];
   int          wait_n = 0;
   int          wcnt = 0;
   int          n_rd = 0;
   int          n_wr = 0;
   int          total = 0;
   int          bad = 0;

   // 0 = RAM (low 4 KiB, aliased at the top of the map), 1 = accel write window, 2 = accel read window, 3 = hole
   function automatic int region(input logic [31:0] a);
      if (a < 32'h1000 || a >= 32'hFFFF_F000) return 0;
      if (a >= ADDR_WRITE && a < ADDR_READ) return 1;
      if (a >= ADDR_READ && a < ADDR_END) return 2;
      return 3;
   endfunction

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      logic [31:0] p;
      case (region(a))
         0: return ram[a[11:2]];
         2: begin
            if (a != ADDR_READ) return 32'h0;
            p = 32'd1;
            for (int i = 0; i < 8; i++) p = p * acc_op[i];
            return p;
         end
         default: return 32'h0;
      endcase
   endfunction

   // Ready is registered and repeats for one cycle after completion (stale ready in the gap).
   always @(posedge clk) begin
      if (reset) begin
         mem_ready <= 1'b0;
         wcnt      <= 0;
      end else if (mem_valid && mem_ready) begin
         log_addr.push_back(mem_addr);
         if (mem_wstrb != 4'h0) begin
            n_wr <= n_wr + 1;
            if (region(mem_addr) == 0) ram[mem_addr[11:2]] <= mem_wdata;
            if (region(mem_addr) == 1) acc_op[mem_addr[4:2]] <= mem_wdata;
         end else begin
            n_rd <= n_rd + 1;
         end
         mem_ready <= 1'b1;
         wcnt      <= 0;
      end else if (mem_valid && region(mem_addr) != 3) begin
         if (wcnt == wait_n) begin
            mem_ready <= 1'b1;
            mem_rdata <= rd_val(mem_addr);
         end else begin
            wcnt      <= wcnt + 1;
            mem_ready <= 1'b0;
         end
      end else begin
         mem_ready <= 1'b0;
         if (!mem_valid) wcnt <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = l;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // lat = negedge samples from accept to done; vcyc = cycles with mem_valid high
   task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          input bit hold, output int lat, output int vcyc);
      start_cmd(s, d, l);
      lat = 1; vcyc = 0;
      while (!done && lat < 3000) begin
         if (mem_valid) vcyc++;
         if (hold && busy) begin
            chk("ready_while_busy", cmd_ready, 1'b0);
            cmd_valid = 1'b1; cmd_src = 32'h40; cmd_dst = 32'h80; cmd_len = 16'd5;
         end
         @(negedge clk);
         lat++;
      end
      cmd_valid = 1'b0;
      chk("done_seen", done, 1'b1);
   endtask

   initial begin
      int lat, vcyc, rd0, wr0, base, k;
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      for (int i = 0; i < 8; i++) begin
         ram[32'h40 + i] = 32'(i + 1);
         acc_op[i] = 32'h0;
      end
      ram[32'h81]  = 32'h5555_5555;
      ram[32'h50]  = 32'hCAFE_0001;
      ram[32'h51]  = 32'hCAFE_0002;
      ram[32'h3FF] = 32'hA5A5_0001;
      ram[32'h000] = 32'hB4B4_0002;
      ram[32'h101] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_valid", mem_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_words", words_done, 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_wstrb", mem_wstrb, 32'h0);

      // 1: operands into the accelerator, then the result back into RAM
      rd0 = n_rd; wr0 = n_wr;
      run_cmd(32'h100, ADDR_WRITE, 16'd8, 1'b0, lat, vcyc);
      chk("t1_valid_cycles", vcyc, 32'd32);
      chk("t1_reads", n_rd - rd0, 32'd8);
      chk("t1_writes", n_wr - wr0, 32'd8);
      chk("t1_err", err, 1'b0);
      chk("t1_words", words_done, 32'd8);
      for (int i = 0; i < 8; i++) chk("t1_operand", acc_op[i], 32'(i + 1));
      run_cmd(ADDR_READ, 32'h200, 16'd2, 1'b0, lat, vcyc);
      chk("t1_result", ram[32'h80], 32'h0000_9D80);
      chk("t1_result_hi", ram[32'h81], 32'h0);

      // 3: write into a hole hangs and times out
      wr0 = n_wr;
      run_cmd(32'h100, 32'h0160_0000, 16'd3, 1'b0, lat, vcyc);
      chk("t3_valid_cycles", vcyc, 32'd66);
      chk("t3_err", err, 1'b1);
      chk("t3_words", words_done, 32'd0);
      chk("t3_writes", n_wr - wr0, 32'd0);
      repeat (3) @(negedge clk);
      chk("t3_valid_after", mem_valid, 1'b0);
      chk("t3_err_held", err, 1'b1);

      // 2: zero-length command
      run_cmd(32'h100, 32'h200, 16'd0, 1'b0, lat, vcyc);
      chk("t2_latency", lat, 32'd1);
      chk("t2_valid_cycles", vcyc, 32'd0);
      chk("t2_err", err, 1'b0);

      // 4: five wait states per access, stale ready in every gap
      wait_n = 5; rd0 = n_rd; wr0 = n_wr;
      run_cmd(32'h140, 32'h180, 16'd2, 1'b0, lat, vcyc);
      chk("t4_valid_cycles", vcyc, 32'd28);
      chk("t4_reads", n_rd - rd0, 32'd2);
      chk("t4_writes", n_wr - wr0, 32'd2);
      chk("t4_word0", ram[32'h60], 32'hCAFE_0001);
      chk("t4_word1", ram[32'h61], 32'hCAFE_0002);
      wait_n = 0;

      // 5: source address wraps through zero; cmd_valid during busy is dropped
      base = log_addr.size();
      run_cmd(32'hFFFF_FFFC, 32'h300, 16'd2, 1'b1, lat, vcyc);
      chk("t5_rd0_addr", log_addr[base], 32'hFFFF_FFFC);
      chk("t5_rd1_addr", log_addr[base + 2], 32'h0);
      chk("t5_word0", ram[32'hC0], 32'hA5A5_0001);
      chk("t5_word1", ram[32'hC1], 32'hB4B4_0002);
      repeat (4) @(negedge clk);
      chk("t5_no_queue", log_addr.size() - base, 32'd4);
      chk("t5_idle", busy, 1'b0);

      // 6: reset in the middle of the second word's write
      start_cmd(32'h100, 32'h400, 16'd3);
      k = 0;
      while (!(mem_valid && mem_wstrb == 4'hF && words_done == 16'd1) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("t6_reached", k < 500, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t6_valid", mem_valid, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_cmd_ready", cmd_ready, 1'b1);
      chk("t6_words", words_done, 32'd0);
      chk("t6_no_done", done, 1'b0);
      chk("t6_first_word", ram[32'h100], 32'd1);
      chk("t6_not_written", ram[32'h101], 32'hDEAD_BEEF);
      run_cmd(32'h100, 32'h500, 16'd2, 1'b0, lat, vcyc);
      chk("t6_new_words", words_done, 32'd2);
      chk("t6_new_err", err, 1'b0);
      chk("t6_new_word0", ram[32'h140], 32'd1);
      chk("t6_new_word1", ram[32'h141], 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
